// File: rtl/layer_post.sv
// Post-accumulator layer stage: per-channel scale (round/shift/saturate/relu)
// followed by a running-max pool over groups of beats, with valid/ready flow control.
module layer_post #(
  parameter int                    CFG_DWIDTH = 32,
  parameter int                    CFG_AWIDTH = 5,
  parameter logic [CFG_AWIDTH-1:0] CFG_ADDR   = '0,
  parameter int                    DEPTH_NB   = 16,
  parameter int                    IMG_WIDTH  = 16,
  parameter int                    NUM_WIDTH  = 33
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [NUM_WIDTH*DEPTH_NB-1:0] sum_bus,
  input  logic                          sum_last,
  input  logic                          sum_val,
  output logic                          sum_rdy,
  output logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
  output logic                          result_last,
  output logic                          result_val,
  input  logic                          result_rdy
);

  localparam int MAX_SH = NUM_WIDTH - IMG_WIDTH;
  localparam logic signed [NUM_WIDTH:0] ONE   = 1;
  localparam logic signed [NUM_WIDTH:0] MAX_V =
    {{(NUM_WIDTH-IMG_WIDTH+2){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
  localparam logic signed [NUM_WIDTH:0] MIN_V =
    {{(NUM_WIDTH-IMG_WIDTH+2){1'b1}}, {(IMG_WIDTH-1){1'b0}}};

  // One guard bit above the input keeps the rounding add from overflowing.
  function automatic logic signed [NUM_WIDTH:0] rnd_shift(
    input logic signed [NUM_WIDTH-1:0] x, input logic [7:0] sh, input logic rnd);
    logic signed [NUM_WIDTH:0] ext;
    ext = {x[NUM_WIDTH-1], x};
    if (rnd && (sh != 8'd0))
      ext = ext + (ONE <<< (sh - 8'd1));
    return ext >>> sh;
  endfunction

  function automatic logic signed [IMG_WIDTH-1:0] sat_clip(
    input logic signed [NUM_WIDTH:0] v, input logic sat);
    if (sat && (v > MAX_V)) return MAX_V[IMG_WIDTH-1:0];
    if (sat && (v < MIN_V)) return MIN_V[IMG_WIDTH-1:0];
    return v[IMG_WIDTH-1:0];
  endfunction

  logic [7:0] shift_q, pool_n_q;
  logic       relu_q, round_q, sat_q;
  logic       rdy_en_q;
  logic       s_vld_q, s_last_q;
  logic [7:0] cnt_q;
  logic       res_vld_q, res_last_q;
  logic signed [IMG_WIDTH-1:0] s_data_q [DEPTH_NB];
  logic signed [IMG_WIDTH-1:0] max_q    [DEPTH_NB];
  logic signed [IMG_WIDTH-1:0] res_q    [DEPTH_NB];
  logic signed [IMG_WIDTH-1:0] s_data_d [DEPTH_NB];
  logic signed [IMG_WIDTH-1:0] max_d    [DEPTH_NB];

  logic       cfg_we, in_take, pool_take, closing;
  logic [7:0] sh_eff, pool_eff;
  logic       unused_cfg;

  assign unused_cfg = ^cfg_data;

  always_comb begin
    cfg_we    = cfg_valid && (cfg_addr == CFG_ADDR);
    sh_eff    = (shift_q > 8'(MAX_SH)) ? 8'(MAX_SH) : shift_q;
    pool_eff  = (pool_n_q == 8'd0) ? 8'd1 : pool_n_q;
    closing   = s_last_q || (cnt_q == pool_eff - 8'd1);
    // A closing beat may only leave when the output register is free or draining.
    pool_take = s_vld_q && !(closing && res_vld_q && !result_rdy);
    sum_rdy   = rdy_en_q && (!s_vld_q || pool_take);
    in_take   = sum_val && sum_rdy;
    for (int c = 0; c < DEPTH_NB; c++) begin
      s_data_d[c] = sat_clip(rnd_shift($signed(sum_bus[c*NUM_WIDTH +: NUM_WIDTH]),
                                       sh_eff, round_q), sat_q);
      if (relu_q && s_data_d[c][IMG_WIDTH-1])
        s_data_d[c] = '0;
      max_d[c] = ((cnt_q == 8'd0) || (s_data_q[c] > max_q[c])) ? s_data_q[c] : max_q[c];
    end
  end

  always_comb begin
    result_bus = '0;
    for (int c = 0; c < DEPTH_NB; c++)
      result_bus[c*IMG_WIDTH +: IMG_WIDTH] = res_q[c];
  end
  assign result_val  = res_vld_q;
  assign result_last = res_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= 8'd0;
      pool_n_q   <= 8'd1;
      relu_q     <= 1'b0;
      round_q    <= 1'b0;
      sat_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
      s_vld_q    <= 1'b0;
      s_last_q   <= 1'b0;
      cnt_q      <= 8'd0;
      res_vld_q  <= 1'b0;
      res_last_q <= 1'b0;
      for (int c = 0; c < DEPTH_NB; c++) res_q[c] <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (cfg_we) begin
        shift_q  <= cfg_data[7:0];
        pool_n_q <= cfg_data[15:8];
        relu_q   <= cfg_data[16];
        round_q  <= cfg_data[17];
        sat_q    <= cfg_data[18];
      end
      // _p0: scale register
      if (in_take) begin
        s_vld_q  <= 1'b1;
        s_last_q <= sum_last;
      end else if (pool_take) begin
        s_vld_q  <= 1'b0;
      end
      // _p1: pool counter and output register
      if (cfg_we)
        cnt_q <= 8'd0;
      else if (pool_take)
        cnt_q <= closing ? 8'd0 : cnt_q + 8'd1;
      if (pool_take && closing) begin
        res_vld_q  <= 1'b1;
        res_last_q <= s_last_q;
        for (int c = 0; c < DEPTH_NB; c++) res_q[c] <= max_d[c];
      end else if (res_vld_q && result_rdy) begin
        res_vld_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_take)
      for (int c = 0; c < DEPTH_NB; c++) s_data_q[c] <= s_data_d[c];
    if (pool_take)
      for (int c = 0; c < DEPTH_NB; c++) max_q[c] <= max_d[c];
  end

endmodule

// File: tb/tb_layer_post.sv
// Directed bench for layer_post: scaling, saturation, relu, pooling, back-pressure and reset.
module tb_layer_post;
  localparam int NW = 33;
  localparam int IW = 16;
  localparam int DN = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cfg_data;
  logic [4:0]        cfg_addr;
  logic              cfg_valid;
  logic [NW*DN-1:0]  sum_bus;
  logic              sum_last, sum_val, sum_rdy;
  logic [IW*DN-1:0]  result_bus;
  logic              result_last, result_val, result_rdy;

  int errs   = 0;
  int checks = 0;

  layer_post dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .sum_bus(sum_bus), .sum_last(sum_last), .sum_val(sum_val), .sum_rdy(sum_rdy),
    .result_bus(result_bus), .result_last(result_last), .result_val(result_val),
    .result_rdy(result_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_at(input logic [4:0] addr, input int sh, input int pn,
                        input logic relu, input logic rnd, input logic sat);
    cfg_data        = '0;
    cfg_data[7:0]   = 8'(sh);
    cfg_data[15:8]  = 8'(pn);
    cfg_data[16]    = relu;
    cfg_data[17]    = rnd;
    cfg_data[18]    = sat;
    cfg_addr        = addr;
    cfg_valid       = 1'b1;
    @(posedge clk); #1;
    cfg_valid       = 1'b0;
  endtask

  task automatic cfg(input int sh, input int pn, input logic relu, input logic rnd,
                     input logic sat);
    cfg_at(5'd0, sh, pn, relu, rnd, sat);
  endtask

  // Returns at 1ns after the edge on which the beat transferred.
  task automatic send(input int v, input logic last, input int vhi);
    bit ok;
    ok = 0;
    sum_bus = '0;
    sum_bus[0 +: NW]        = NW'(v);
    sum_bus[(DN-1)*NW +: NW] = NW'(vhi);
    sum_last = last;
    sum_val  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sum_rdy) begin ok = 1; break; end
    end
    if (!ok) chk("send_rdy", {31'd0, sum_rdy}, 32'd1);
    @(posedge clk); #1;
    sum_val  = 1'b0;
    sum_last = 1'b0;
  endtask

  // Single-beat group: nothing visible right after the transfer edge, result one edge later.
  task automatic one(input string tag, input int v, input logic last,
                     input logic [15:0] exp, input logic exp_last);
    send(v, last, 0);
    chk({tag, "_lat"}, {31'd0, result_val}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_val"},  {31'd0, result_val}, 32'd1);
    chk({tag, "_ch0"},  {16'd0, result_bus[15:0]}, {16'd0, exp});
    chk({tag, "_last"}, {31'd0, result_last}, {31'd0, exp_last});
  endtask

  initial begin
    int  idx, got;
    bit  tx;
    rst = 1'b1; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;
    sum_bus = '0; sum_last = 1'b0; sum_val = 1'b0; result_rdy = 1'b1;
    #1;
    chk("rst_val",  {31'd0, result_val}, 32'd0);
    chk("rst_last", {31'd0, result_last}, 32'd0);
    chk("rst_bus",  result_bus[31:0], 32'd0);
    chk("rst_rdy",  {31'd0, sum_rdy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rdy_after_rst_low", {31'd0, sum_rdy}, 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_rst_rise", {31'd0, sum_rdy}, 32'd1);

    // Basic scale with latency and top-channel packing
    cfg(4, 1, 0, 0, 0);
    send(256, 1'b1, -512);
    chk("lat_t1", {31'd0, result_val}, 32'd0);
    @(posedge clk); #1;
    chk("lat_t2",  {31'd0, result_val}, 32'd1);
    chk("sh4_ch0", {16'd0, result_bus[15:0]}, 32'h0010);
    chk("sh4_top", {16'd0, result_bus[(DN-1)*IW +: IW]}, 32'hFFE0);
    chk("sh4_last", {31'd0, result_last}, 32'd1);
    @(posedge clk); #1;
    chk("drained", {31'd0, result_val}, 32'd0);

    // Rounding
    cfg(4, 1, 0, 1, 0);
    one("rnd24", 24, 1'b0, 16'd2, 1'b0);
    cfg(4, 1, 0, 0, 0);
    one("trunc24", 24, 1'b0, 16'd1, 1'b0);
    one("truncm24", -24, 1'b0, 16'hFFFE, 1'b0);

    // Address mismatch leaves shift=4 in place
    cfg_at(5'd3, 0, 1, 0, 0, 0);
    one("badaddr", 256, 1'b0, 16'h0010, 1'b0);

    // Saturation and relu
    cfg(0, 1, 0, 0, 1);
    one("satpos", 40000, 1'b0, 16'h7FFF, 1'b0);
    one("satneg", -40000, 1'b0, 16'h8000, 1'b0);
    cfg(0, 1, 0, 0, 0);
    one("wrap", 40000, 1'b0, 16'h9C40, 1'b0);
    cfg(0, 1, 1, 0, 1);
    one("relusat", -40000, 1'b0, 16'h0000, 1'b0);

    // Shift clamp to 17, pool_n 0 acts as 1
    cfg(200, 0, 0, 0, 0);
    one("clamp", 1 << 20, 1'b0, 16'd8, 1'b0);

    // Pooling with relu
    cfg(0, 3, 1, 0, 0);
    send(-5, 1'b0, 0);
    send(7, 1'b0, 0);
    send(2, 1'b0, 0);
    chk("pool3_early", {31'd0, result_val}, 32'd0);
    @(posedge clk); #1;
    chk("pool3_val", {31'd0, result_val}, 32'd1);
    chk("pool3_max", {16'd0, result_bus[15:0]}, 32'd7);
    chk("pool3_last", {31'd0, result_last}, 32'd0);
    send(-5, 1'b0, 0);
    send(7, 1'b1, 0);
    @(posedge clk); #1;
    chk("poolL_val", {31'd0, result_val}, 32'd1);
    chk("poolL_max", {16'd0, result_bus[15:0]}, 32'd7);
    chk("poolL_last", {31'd0, result_last}, 32'd1);
    send(2, 1'b0, 0);
    send(-9, 1'b0, 0);
    send(1, 1'b0, 0);
    @(posedge clk); #1;
    chk("poolN_val", {31'd0, result_val}, 32'd1);
    chk("poolN_max", {16'd0, result_bus[15:0]}, 32'd2);

    // Config write discards a partial group
    cfg(0, 2, 0, 0, 0);
    send(50, 1'b0, 0);
    cfg(0, 2, 0, 0, 0);
    send(3, 1'b0, 0);
    send(4, 1'b0, 0);
    @(posedge clk); #1;
    chk("cfgclr_val", {31'd0, result_val}, 32'd1);
    chk("cfgclr_max", {16'd0, result_bus[15:0]}, 32'd4);

    // Back-pressure: six beats, output stalled for the first five cycles
    cfg(0, 1, 0, 0, 0);
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (got >= 6) break;
      result_rdy = (cyc >= 5);
      sum_val    = (idx < 6);
      sum_bus    = '0;
      sum_bus[0 +: NW] = NW'(101 + idx);
      sum_last   = (idx == 5);
      @(negedge clk);
      if (cyc == 3) chk("stall_rdy", {31'd0, sum_rdy}, 32'd0);
      if (result_val) begin
        chk("stream_data", {16'd0, result_bus[15:0]}, 32'(101 + got));
        chk("stream_last", {31'd0, result_last}, {31'd0, (got == 5)});
        if (result_rdy) got++;
      end
      tx = sum_val && sum_rdy;
      @(posedge clk); #1;
      if (tx) idx++;
    end
    sum_val = 1'b0; sum_last = 1'b0; result_rdy = 1'b1;
    chk("stream_count", 32'(got), 32'd6);
    chk("stream_nodup", {31'd0, result_val}, 32'd0);

    // Asynchronous reset mid-group with a result pending
    cfg(4, 2, 0, 0, 0);
    result_rdy = 1'b0;
    send(256, 1'b0, 0);
    send(256, 1'b0, 0);
    send(256, 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_val", {31'd0, result_val}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_val", {31'd0, result_val}, 32'd0);
    chk("async_rst_bus", result_bus[31:0], 32'd0);
    chk("async_rst_rdy", {31'd0, sum_rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; result_rdy = 1'b1;
    @(posedge clk); #1;
    one("post_rst", 256, 1'b0, 16'd256, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
